// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
//   mode_t        - operating mode of the PC unit (RUN / HANDLER / HALTED)
//   CAUSE_W       - width of the trap cause code
//   DEF_*         - default reset vector, trap vector and sequential increment
package pc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALTED  = 2'd2
  } mode_t;

  localparam int CAUSE_W = 6;

  localparam longint unsigned DEF_RESET_VECTOR = 64'd1023;
  localparam longint unsigned DEF_TRAP_VECTOR  = 64'd0;
  localparam longint unsigned DEF_INC          = 64'd4;

endpackage

// File: rtl/pc_unit_return_addr_stack.sv
// return_addr_stack: circular return-address stack with overwrite-on-full.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   push, pop           - already-qualified push / pop requests
//   push_data [XLEN]    - address written on push
//   top       [XLEN]    - entry at the top pointer
//   valid               - stack holds at least one entry
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int TW = $clog2(DEPTH);
  localparam int CW = TW + 1;

  logic [XLEN-1:0] entries [DEPTH];
  logic [TW-1:0]   tp_reg;
  logic [CW-1:0]   cnt_reg;

  logic            empty;
  logic            wr_en;
  logic [TW-1:0]   wr_idx;

  assign empty = (cnt_reg == '0);

  // Push+pop on a non-empty stack replaces the top in place; on an empty
  // stack it degrades to a plain push.
  always_comb begin
    wr_en  = push;
    wr_idx = tp_reg + TW'(1);
    if (push && pop && !empty) begin
      wr_idx = tp_reg;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        entries[gi] <= '0;
      end else if (wr_en && (wr_idx == TW'(gi))) begin
        entries[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tp_reg  <= '0;
      cnt_reg <= '0;
    end else if (push && pop && !empty) begin
      tp_reg  <= tp_reg;
      cnt_reg <= cnt_reg;
    end else if (push) begin
      tp_reg <= tp_reg + TW'(1);
      // When full the oldest entry has just been overwritten; count saturates.
      if (cnt_reg != CW'(DEPTH)) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end else if (pop && !empty) begin
      tp_reg  <= tp_reg - TW'(1);
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign top   = entries[tp_reg];
  assign valid = !empty;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: RV64 fetch-stage program counter with trap entry/return,
// double-fault halt and a return-address stack.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   stall                 - hold pc this cycle
//   redirect, redirect_pc - taken branch/jump target (overrides stall)
//   trap, trap_cause      - exception entry and its cause code
//   mret                  - return from handler
//   ras_push, ras_pop     - call / return retired
//   pc                    - current fetch address
//   epc, cause            - saved trapping pc and cause
//   mode                  - 0 RUN, 1 HANDLER, 2 HALTED
//   ras_top, ras_valid    - predicted return target and RAS non-empty flag
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter logic [XLEN-1:0] INC          = XLEN'(DEF_INC),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               trap,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic               mret,
  input  logic               ras_push,
  input  logic               ras_pop,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    epc,
  output logic [CAUSE_W-1:0] cause,
  output logic [1:0]         mode,
  output logic [XLEN-1:0]    ras_top,
  output logic               ras_valid
);

  mode_t           mode_reg;
  logic [XLEN-1:0] pc_inc;
  logic            ras_active;

  assign pc_inc = pc + INC;  // wraps modulo 2^XLEN

  // RAS is frozen while halted and ignores requests in a trap cycle.
  assign ras_active = !trap && (mode_reg != HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_VECTOR;
      epc      <= '0;
      cause    <= '0;
      mode_reg <= RUN;
    end else begin
      case (mode_reg)
        RUN: begin
          if (trap) begin
            epc      <= pc;
            cause    <= trap_cause;
            pc       <= TRAP_VECTOR;
            mode_reg <= HANDLER;
          end else if (redirect) begin
            pc <= redirect_pc;
          end else if (!stall) begin
            pc <= pc_inc;
          end
        end
        HANDLER: begin
          if (trap) begin
            // Double fault: freeze everything until reset.
            mode_reg <= HALTED;
          end else if (mret) begin
            pc       <= epc;
            mode_reg <= RUN;
          end else if (redirect) begin
            pc <= redirect_pc;
          end else if (!stall) begin
            pc <= pc_inc;
          end
        end
        default: begin
          mode_reg <= HALTED;
        end
      endcase
    end
  end

  assign mode = mode_reg;

  return_addr_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push && ras_active),
    .pop       (ras_pop && ras_active),
    .push_data (pc_inc),
    .top       (ras_top),
    .valid     (ras_valid)
  );

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        trap;
  logic [5:0]  trap_cause;
  logic        mret;
  logic        ras_push;
  logic        ras_pop;
  logic [63:0] pc;
  logic [63:0] epc;
  logic [5:0]  cause;
  logic [1:0]  mode;
  logic [63:0] ras_top;
  logic        ras_valid;

  pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .mret        (mret),
    .ras_push    (ras_push),
    .ras_pop     (ras_pop),
    .pc          (pc),
    .epc         (epc),
    .cause       (cause),
    .mode        (mode),
    .ras_top     (ras_top),
    .ras_valid   (ras_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // check mask bits: pc, epc, cause, mode, ras (top + valid)
  localparam logic [4:0] M_PC   = 5'b00001;
  localparam logic [4:0] M_EPC  = 5'b00010;
  localparam logic [4:0] M_CAU  = 5'b00100;
  localparam logic [4:0] M_MODE = 5'b01000;
  localparam logic [4:0] M_RAS  = 5'b10000;
  localparam logic [4:0] M_ALL  = 5'b11111;

  typedef struct {
    string       nm;
    logic [4:0]  m;
    logic [63:0] pc;
    logic [63:0] epc;
    logic [5:0]  cause;
    logic [1:0]  mode;
    logic [63:0] top;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: the DUT presents a new state after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.m[0]) chk(e.nm, "pc", pc, e.pc);
        if (e.m[1]) chk(e.nm, "epc", epc, e.epc);
        if (e.m[2]) chk(e.nm, "cause", 64'(cause), 64'(e.cause));
        if (e.m[3]) chk(e.nm, "mode", 64'(mode), 64'(e.mode));
        if (e.m[4]) begin
          chk(e.nm, "ras_top", ras_top, e.top);
          chk(e.nm, "ras_valid", 64'(ras_valid), 64'(e.valid));
        end
        $display("vec %-14s pc=0x%0h epc=0x%0h cause=%0d mode=%0d ras_top=0x%0h ras_valid=%0b",
                 e.nm, pc, epc, cause, mode, ras_top, ras_valid);
      end
    end
  end

  // Inputs are set by the caller; this queues the expected post-edge state,
  // advances one cycle, and clears all event inputs.
  task automatic tick(input string nm, input logic [4:0] m, input logic [63:0] e_pc,
                      input logic [63:0] e_epc, input logic [5:0] e_cause, input logic [1:0] e_mode,
                      input logic [63:0] e_top, input logic e_valid);
    exp_t e;
    e.nm = nm; e.m = m; e.pc = e_pc; e.epc = e_epc; e.cause = e_cause;
    e.mode = e_mode; e.top = e_top; e.valid = e_valid;
    exp_q.push_back(e);
    @(negedge clk);
    reset = 0; stall = 0; redirect = 0; redirect_pc = '0; trap = 0;
    trap_cause = '0; mret = 0; ras_push = 0; ras_pop = 0;
  endtask

  initial begin
    reset = 1; stall = 0; redirect = 0; redirect_pc = '0; trap = 0;
    trap_cause = '0; mret = 0; ras_push = 0; ras_pop = 0;
    @(negedge clk);

    reset = 1;                   tick("reset", M_ALL, 64'd1023, 64'd0, 6'd0, 2'd0, 64'd0, 1'b0);
                                 tick("inc1", M_PC, 64'd1027, 0, 0, 0, 0, 0);
                                 tick("inc2", M_PC, 64'd1031, 0, 0, 0, 0, 0);
                                 tick("inc3", M_PC, 64'd1035, 0, 0, 0, 0, 0);
    stall = 1;                   tick("stall", M_PC | M_MODE, 64'd1035, 0, 0, 2'd0, 0, 0);
    redirect = 1; redirect_pc = 64'h200; stall = 1;
                                 tick("redir_stall", M_PC, 64'h200, 0, 0, 0, 0, 0);
    redirect = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
                                 tick("redir_top", M_PC, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0);
                                 tick("wrap", M_PC, 64'd0, 0, 0, 0, 0, 0);

    // trap / mret / double fault
    redirect = 1; redirect_pc = 64'h300;
                                 tick("to_300", M_PC, 64'h300, 0, 0, 0, 0, 0);
    trap = 1; trap_cause = 6'd5; ras_push = 1;
                                 tick("trap5", M_ALL, 64'd0, 64'h300, 6'd5, 2'd1, 64'd0, 1'b0);
    mret = 1;                    tick("mret", M_PC | M_MODE | M_EPC, 64'h300, 64'h300, 0, 2'd0, 0, 0);
    mret = 1;                    tick("mret_run", M_PC | M_MODE, 64'h304, 0, 0, 2'd0, 0, 0);
    trap = 1; trap_cause = 6'd3; tick("trap3", M_PC | M_EPC | M_CAU | M_MODE, 64'd0, 64'h304, 6'd3, 2'd1, 0, 0);
    trap = 1; trap_cause = 6'd7; tick("dbl_fault", M_ALL, 64'd0, 64'h304, 6'd3, 2'd2, 64'd0, 1'b0);
    redirect = 1; redirect_pc = 64'h500; mret = 1;
                                 tick("halt_redir", M_PC | M_MODE, 64'd0, 0, 0, 2'd2, 0, 0);
    trap = 1; trap_cause = 6'd9; ras_push = 1;
                                 tick("halt_trap", M_ALL, 64'd0, 64'h304, 6'd3, 2'd2, 64'd0, 1'b0);
    ras_push = 1;                tick("halt_push", M_PC | M_RAS, 64'd0, 0, 0, 0, 64'd0, 1'b0);
    reset = 1;                   tick("reset2", M_ALL, 64'd1023, 64'd0, 6'd0, 2'd0, 64'd0, 1'b0);

    // RAS: 5 pushes into a 4-deep stack
    redirect = 1; redirect_pc = 64'h10;
                                 tick("to_10", M_PC, 64'h10, 0, 0, 0, 0, 0);
    ras_push = 1; redirect = 1; redirect_pc = 64'h20;
                                 tick("push1", M_PC | M_RAS, 64'h20, 0, 0, 0, 64'h14, 1'b1);
    ras_push = 1; redirect = 1; redirect_pc = 64'h30;
                                 tick("push2", M_RAS, 0, 0, 0, 0, 64'h24, 1'b1);
    ras_push = 1; redirect = 1; redirect_pc = 64'h40;
                                 tick("push3", M_RAS, 0, 0, 0, 0, 64'h34, 1'b1);
    ras_push = 1; redirect = 1; redirect_pc = 64'h50;
                                 tick("push4", M_RAS, 0, 0, 0, 0, 64'h44, 1'b1);
    ras_push = 1; redirect = 1; redirect_pc = 64'h80;
                                 tick("push5", M_PC | M_RAS, 64'h80, 0, 0, 0, 64'h54, 1'b1);
    ras_pop = 1; stall = 1;      tick("pop1", M_PC | M_RAS, 64'h80, 0, 0, 0, 64'h44, 1'b1);
    ras_pop = 1; stall = 1;      tick("pop2", M_RAS, 0, 0, 0, 0, 64'h34, 1'b1);
    ras_pop = 1; stall = 1;      tick("pop3", M_RAS, 0, 0, 0, 0, 64'h24, 1'b1);
    ras_pop = 1; stall = 1;      tick("pop4", M_RAS, 0, 0, 0, 0, 64'h54, 1'b0);
    ras_pop = 1; stall = 1;      tick("pop_empty", M_RAS, 0, 0, 0, 0, 64'h54, 1'b0);

    // push+pop replaces top in place
    redirect = 1; redirect_pc = 64'h10;
                                 tick("to_10b", M_PC, 64'h10, 0, 0, 0, 0, 0);
    ras_push = 1; redirect = 1; redirect_pc = 64'h80;
                                 tick("push_14", M_PC | M_RAS, 64'h80, 0, 0, 0, 64'h14, 1'b1);
    ras_push = 1; ras_pop = 1; stall = 1;
                                 tick("pushpop", M_PC | M_RAS, 64'h80, 0, 0, 0, 64'h84, 1'b1);
    ras_pop = 1; stall = 1;      tick("pop_cnt1", M_RAS, 0, 0, 0, 0, 64'h54, 1'b0);
    ras_push = 1; ras_pop = 1; stall = 1;
                                 tick("pushpop_empty", M_RAS, 0, 0, 0, 0, 64'h84, 1'b1);
    ras_push = 1; trap = 1; trap_cause = 6'd2;
                                 tick("push_trap", M_ALL, 64'd0, 64'h80, 6'd2, 2'd1, 64'h84, 1'b1);
    mret = 1;                    tick("mret2", M_PC | M_MODE | M_RAS, 64'h80, 0, 0, 2'd0, 64'h84, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the RV64 fetch stage; successor to the single-register PC. It holds the fetch address, auto-increments, and accepts stalls, branch/jump redirects, trap entry and trap return (`mret`). It keeps an exception PC and cause, and provides a small return-address stack (RAS) for call/return target prediction. All state is registered; fetch reads `pc` directly.

## Interface
- `XLEN`, 64: PC/data width in bits.
- `RESET_VECTOR`, 1023: PC value after reset.
- `TRAP_VECTOR`, 0: PC loaded on trap entry.
- `INC`, 4: sequential increment.
- `RAS_DEPTH`, 4: RAS entries; power of two, ≥2.
- `clk` in 1: clock.
- `reset` in 1: reset; synchronous, active-high.
- `stall` in 1: hold PC this cycle.
- `redirect` in 1: load `redirect_pc` (branch/jump taken).
- `redirect_pc` in XLEN: redirect target.
- `trap` in 1: take exception; `trap_cause` in 6: cause code.
- `mret` in 1: return from handler.
- `ras_push` in 1: call retired; push `pc+INC`.
- `ras_pop` in 1: return retired; pop top.
- `pc` out XLEN: current fetch address.
- `epc` out XLEN: saved PC of the trapping instruction; `cause` out 6: saved cause.
- `mode` out 2: 0 RUN, 1 HANDLER, 2 HALTED.
- `ras_top` out XLEN: predicted return target; `ras_valid` out 1: RAS non-empty.

## Operation
- FSM: RUN, HANDLER, HALTED.
  - RUN --trap--> HANDLER.
  - HANDLER --mret--> RUN.
  - HANDLER --trap--> HALTED (double fault).
  - HALTED exits only on reset.
- PC update priority per cycle (highest first): reset, then trap, then mret, then redirect, then stall, then increment.
  - reset: `pc`=RESET_VECTOR.
  - trap (RUN): `epc`←`pc`, `cause`←`trap_cause`, `pc`←TRAP_VECTOR.
  - trap (HANDLER): `pc` frozen, `epc`/`cause` unchanged, go HALTED.
  - mret in HANDLER: `pc`←`epc`. mret in RUN or HALTED is ignored and acts as no event (lower priorities apply in RUN).
  - redirect: `pc`←`redirect_pc`, even when `stall`=1.
  - stall: `pc` holds.
  - otherwise: `pc`←`pc`+INC, modulo 2^XLEN (wraps silently).
- HALTED: `pc`, `epc`, `cause` and RAS are frozen; all inputs except reset are ignored.
- RAS: circular buffer with top pointer `tp` (log2 RAS_DEPTH bits) and count `cnt` (0..RAS_DEPTH).
  - push: write `pc+INC` at `tp+1`, advance `tp`, `cnt`=min(cnt+1, RAS_DEPTH). When full, the oldest entry is overwritten.
  - pop: if `cnt`>0, decrement `tp` and `cnt`. Pop when empty is ignored.
  - push and pop in the same cycle: overwrite top in place with `pc+INC`; `tp` and `cnt` unchanged. If empty, treat as a plain push.
  - RAS operations are ignored when `trap` is taken that cycle.
- `ras_top` = entry[`tp`]. `ras_valid` = (`cnt`≠0).

## Timing
- Reset values: `pc`=RESET_VECTOR, `epc`=0, `cause`=0, `mode`=RUN, `cnt`=0, `tp`=0, `ras_valid`=0, `ras_top`=0 (entries cleared).
- All outputs are registered. Every event takes effect on the `pc` value visible after the same rising edge (1-cycle latency). No combinational input-to-output paths.
- `epc` captures the pre-edge `pc` value.
- Reset mid-trap or mid-halt returns to RUN with the values above in one cycle.

## Structure
- Shared package `pc_pkg`: `mode_t` enum (RUN=0, HANDLER=1, HALTED=2), cause width constant (6), default vectors.
- One sub-module `return_addr_stack` (RAS storage, pointer, count, push/pop arbitration). The FSM and PC mux live in `pc_unit`.

## Test plan
- Reset then 3 free-running cycles: `pc` = 1023, 1027, 1031, 1035. Assert `stall` one cycle: `pc` holds 1035.
- `redirect`=1 with `redirect_pc`=0x200 and `stall`=1 → next `pc`=0x200. `pc`=2^64−4 with no event → next `pc`=0.
- At `pc`=0x300, `trap`=1 with cause 5 → `pc`=0, `epc`=0x300, `cause`=5, `mode`=1. `mret` → `pc`=0x300, `mode`=0. `mret` in RUN → plain increment.
- Trap while in HANDLER → `mode`=2. Any further redirect/mret/trap → `pc` frozen. Reset → `pc`=1023, `mode`=0.
- RAS_DEPTH=4: 5 pushes at `pc`=0x10,0x20,0x30,0x40,0x50 → `ras_top`=0x54. Pops yield 0x54, 0x44, 0x34, 0x24. After 4 pops `ras_valid`=0; a 5th pop is ignored.
- Push and pop in the same cycle at `pc`=0x80 with top 0x14 → `ras_top`=0x84, `cnt` unchanged. Push in the same cycle as trap → RAS unchanged.
